multicycle_ctrl: RTL and testbench



---
 rtl/ctrl_pkg.sv | 42 ++++
 rtl/ctrl_decode.sv | 48 ++++
 rtl/multicycle_ctrl.sv | 116 +++++++++++
 tb/tb_multicycle_ctrl.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared state encoding, opcode classes, branch condition codes and flag positions
// for the multi-cycle control unit.
package ctrl_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam int B_FETCH  = 0;
  localparam int B_DECODE = 1;
  localparam int B_EXEC   = 2;
  localparam int B_MEM    = 3;
  localparam int B_WB     = 4;
  localparam int B_HALT   = 5;

  typedef enum logic [2:0] {
    C_ALU, C_LOAD, C_STORE, C_BRANCH, C_JUMP, C_NOP, C_HALT, C_ILLEGAL
  } opc_class_t;

  localparam logic [4:0] OPC_LOAD   = 5'b1_0000;
  localparam logic [4:0] OPC_STORE  = 5'b1_0001;
  localparam logic [4:0] OPC_BRANCH = 5'b1_0010;
  localparam logic [4:0] OPC_JUMP   = 5'b1_0011;
  localparam logic [4:0] OPC_NOP    = 5'b1_1110;
  localparam logic [4:0] OPC_HALT   = 5'b1_1111;

  localparam logic [2:0] COND_ALWAYS = 3'b000;
  localparam logic [2:0] COND_Z      = 3'b001;
  localparam logic [2:0] COND_NZ     = 3'b010;
  localparam logic [2:0] COND_N      = 3'b011;
  localparam logic [2:0] COND_C      = 3'b100;

  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_C = 2;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational IR decode: opcode class, register fields and branch-taken.
// Zero latency; no handshake.
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter int INSTR_W = 16,
  parameter int OPC_W   = 5,
  parameter int REG_AW  = 4,
  parameter int COND_W  = 3
) (
  input  logic [INSTR_W-1:0] ir,
  input  logic [2:0]         flags,
  output logic [OPC_W-1:0]   opc,
  output logic [REG_AW-1:0]  dst,
  output logic [REG_AW-1:0]  src,
  output opc_class_t         cls,
  output logic               taken
);

  logic [COND_W-1:0] cond;

  assign opc  = ir[INSTR_W-1 -: OPC_W];
  assign dst  = ir[INSTR_W-OPC_W-1 -: REG_AW];
  assign src  = ir[INSTR_W-OPC_W-REG_AW-1 -: REG_AW];
  assign cond = ir[COND_W-1:0];

  always_comb begin
    cls = C_ILLEGAL;
    if (!opc[OPC_W-1])                 cls = C_ALU;
    else if (opc == OPC_W'(OPC_LOAD))   cls = C_LOAD;
    else if (opc == OPC_W'(OPC_STORE))  cls = C_STORE;
    else if (opc == OPC_W'(OPC_BRANCH)) cls = C_BRANCH;
    else if (opc == OPC_W'(OPC_JUMP))   cls = C_JUMP;
    else if (opc == OPC_W'(OPC_NOP))    cls = C_NOP;
    else if (opc == OPC_W'(OPC_HALT))   cls = C_HALT;
  end

  // Codes 101..111 fall through as never taken.
  always_comb begin
    taken = 1'b0;
    if (cond == COND_W'(COND_ALWAYS))  taken = 1'b1;
    else if (cond == COND_W'(COND_Z))  taken = flags[FLAG_Z];
    else if (cond == COND_W'(COND_NZ)) taken = !flags[FLAG_Z];
    else if (cond == COND_W'(COND_N))  taken = flags[FLAG_N];
    else if (cond == COND_W'(COND_C))  taken = flags[FLAG_C];
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM: fetch/decode/exec/mem/wb, 3-5 cycles per instruction at zero wait;
// stalls indefinitely on instr_ack/mem_ack. CTRL_ILLEGAL_TRAP_EN makes illegal opcodes trap to HALT.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int INSTR_W = 16,
  parameter int OPC_W   = 5,
  parameter int REG_AW  = 4,
  parameter int COND_W  = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [INSTR_W-1:0] instr,
  input  logic               instr_ack,
  output logic               instr_req,
  input  logic [2:0]         flags,
  input  logic               mem_ack,
  output logic               mem_req,
  output logic               mem_we,
  output logic               en_pc_2,
  output logic               branch_en,
  output logic               pc_inc,
  output logic               wr_en,
  output logic [REG_AW-1:0]  wr_reg,
  output logic [REG_AW-1:0]  src_reg,
  output logic [REG_AW-1:0]  dst_reg,
  output logic [OPC_W-1:0]   op_code,
  output logic [5:0]         fsm_state,
  output logic               halted,
  output logic               illegal_op
);

  state_t             state;
  logic [INSTR_W-1:0] ir;
  opc_class_t         cls;
  logic               taken;
  logic [REG_AW-1:0]  dst;

  ctrl_decode #(
    .INSTR_W(INSTR_W), .OPC_W(OPC_W), .REG_AW(REG_AW), .COND_W(COND_W)
  ) u_decode (
    .ir(ir), .flags(flags), .opc(op_code), .dst(dst), .src(src_reg),
    .cls(cls), .taken(taken)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_FETCH;
      ir    <= '0;
    end else begin
      case (state)
        S_FETCH: if (instr_ack) begin
          ir    <= instr;
          state <= S_DECODE;
        end
        S_DECODE: state <= S_EXEC;
        S_EXEC: begin
          case (cls)
            C_ALU:                     state <= S_WB;
            C_LOAD, C_STORE:           state <= S_MEM;
            C_BRANCH, C_JUMP, C_NOP:   state <= S_FETCH;
            C_HALT:                    state <= S_HALT;
`ifdef CTRL_ILLEGAL_TRAP_EN
            default:                   state <= S_HALT;
`else
            default:                   state <= S_FETCH;
`endif
          endcase
        end
        S_MEM:   if (mem_ack) state <= (cls == C_STORE) ? S_FETCH : S_WB;
        S_WB:    state <= S_FETCH;
        S_HALT:  state <= S_HALT;
        default: state <= S_FETCH;
      endcase
    end
  end

`ifdef CTRL_ILLEGAL_TRAP_EN
  logic illegal_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                        illegal_q <= 1'b0;
    else if (state == S_EXEC && cls == C_ILLEGAL)   illegal_q <= 1'b1;
  end
  assign illegal_op = illegal_q;
`else
  assign illegal_op = 1'b0;
`endif

  // Strobes decode straight from the state register so reset removes them asynchronously.
  logic redirect;
  assign redirect  = (state == S_EXEC) && ((cls == C_JUMP) || (cls == C_BRANCH && taken));
  assign instr_req = (state == S_FETCH);
  assign en_pc_2   = (state == S_DECODE);
  assign pc_inc    = (state == S_DECODE) || redirect;
  assign branch_en = redirect;
  assign mem_req   = (state == S_MEM);
  assign mem_we    = (state == S_MEM) && (cls == C_STORE);
  assign wr_en     = (state == S_WB);
  assign halted    = (state == S_HALT);
  assign wr_reg    = dst;
  assign dst_reg   = dst;

  always_comb begin
    fsm_state = '0;
    case (state)
      S_FETCH:  fsm_state[B_FETCH]  = 1'b1;
      S_DECODE: fsm_state[B_DECODE] = 1'b1;
      S_EXEC:   fsm_state[B_EXEC]   = 1'b1;
      S_MEM:    fsm_state[B_MEM]    = 1'b1;
      S_WB:     fsm_state[B_WB]     = 1'b1;
      S_HALT:   fsm_state[B_HALT]   = 1'b1;
      default:  fsm_state           = '0;
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-cycle expected outputs are queued by the stimulus
// and popped and compared by an independent monitor on the falling edge.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] instr;
  logic        instr_ack;
  logic        instr_req;
  logic [2:0]  flags;
  logic        mem_ack, mem_req, mem_we;
  logic        en_pc_2, branch_en, pc_inc, wr_en;
  logic [3:0]  wr_reg, src_reg, dst_reg;
  logic [4:0]  op_code;
  logic [5:0]  fsm_state;
  logic        halted, illegal_op;

  always #5 clk = ~clk;

  multicycle_ctrl dut (
    .clk(clk), .rst(rst), .instr(instr), .instr_ack(instr_ack), .instr_req(instr_req),
    .flags(flags), .mem_ack(mem_ack), .mem_req(mem_req), .mem_we(mem_we),
    .en_pc_2(en_pc_2), .branch_en(branch_en), .pc_inc(pc_inc), .wr_en(wr_en),
    .wr_reg(wr_reg), .src_reg(src_reg), .dst_reg(dst_reg), .op_code(op_code),
    .fsm_state(fsm_state), .halted(halted), .illegal_op(illegal_op)
  );

  localparam logic [5:0] SF = 6'h01, SD = 6'h02, SE = 6'h04, SM = 6'h08, SW = 6'h10, SH = 6'h20;
  // {instr_req, pc_inc, en_pc_2, branch_en, mem_req, mem_we, wr_en, halted, illegal_op}
  localparam logic [8:0] FE  = 9'b1_0000_0000;
  localparam logic [8:0] DE  = 9'b0_1100_0000;
  localparam logic [8:0] NO  = 9'b0_0000_0000;
  localparam logic [8:0] BR  = 9'b0_1010_0000;
  localparam logic [8:0] ML  = 9'b0_0001_0000;
  localparam logic [8:0] MS  = 9'b0_0001_1000;
  localparam logic [8:0] WB  = 9'b0_0000_0100;
  localparam logic [8:0] HL  = 9'b0_0000_0010;
  localparam logic [8:0] HLI = 9'b0_0000_0011;

  logic [31:0] exp_q[$];
  int          vectors = 0;
  int          miscompares = 0;
  logic [15:0] cur_ir;

  always @(negedge clk) begin
    logic [31:0] got, exp_v;
    if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      got = {fsm_state, instr_req, pc_inc, en_pc_2, branch_en, mem_req, mem_we, wr_en,
             halted, illegal_op, wr_reg, src_reg, dst_reg, op_code};
      vectors++;
      if (got !== exp_v) begin
        miscompares++;
        $display("FAIL cycle_trace vec=%0d got state=%h strb=%b wr=%h src=%h dst=%h op=%h, expected state=%h strb=%b wr=%h src=%h dst=%h op=%h",
                 vectors, got[31:26], got[25:17], got[16:13], got[12:9], got[8:5], got[4:0],
                 exp_v[31:26], exp_v[25:17], exp_v[16:13], exp_v[12:9], exp_v[8:5], exp_v[4:0]);
      end
    end
  end

  task automatic check_now(input string tag, input logic [5:0] oh, input logic [8:0] strb);
    logic [14:0] got_s;
    got_s = {fsm_state, instr_req, pc_inc, en_pc_2, branch_en, mem_req, mem_we, wr_en,
             halted, illegal_op};
    vectors++;
    if (got_s !== {oh, strb}) begin
      miscompares++;
      $display("FAIL %s got state=%h strb=%b, expected state=%h strb=%b",
               tag, got_s[14:9], got_s[8:0], oh, strb);
    end
  endtask

  // Fields expected from the instruction the bench believes is latched: op[15:11] dst[10:7] src[6:3].
  task automatic step(input logic [5:0] oh, input logic [8:0] strb);
    exp_q.push_back({oh, strb, cur_ir[10:7], cur_ir[6:3], cur_ir[10:7], cur_ir[15:11]});
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [15:0] i);
    instr = i;
    instr_ack = 1'b1;
    step(SF, FE);
    cur_ir = i;
    instr_ack = 1'b0;
    instr = 16'h0000;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cur_ir = 16'h0000;
    #1;
    check_now("reset_state", SF, FE);
    step(SF, FE);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; instr = 16'h0000; instr_ack = 1'b0; mem_ack = 1'b0; flags = 3'b000;
    cur_ir = 16'h0000;
    repeat (2) @(posedge clk);
    #1;
    step(SF, FE);
    rst = 1'b0;
    step(SF, FE);

    // ALU 0x0A53: op 00001, dst 4, src A; stray instr_ack after FETCH must not reload IR.
    fetch(16'h0A53);
    instr = 16'hF800; instr_ack = 1'b1;
    step(SD, DE);
    step(SE, NO);
    step(SW, WB);
    instr_ack = 1'b0; instr = 16'h0000;
    step(SF, FE);

    // LOAD dst 3 src 5 with mem_ack three cycles late: 8 cycles FETCH to FETCH.
    fetch(16'h81A8);
    step(SD, DE);
    step(SE, NO);
    step(SM, ML); step(SM, ML); step(SM, ML);
    mem_ack = 1'b1;
    step(SM, ML);
    mem_ack = 1'b0;
    step(SW, WB);
    step(SF, FE);

    // STORE zero-wait.
    fetch(16'h8908);
    step(SD, DE);
    step(SE, NO);
    mem_ack = 1'b1;
    step(SM, MS);
    mem_ack = 1'b0;

    // BRANCH cond Z, taken then not taken.
    fetch(16'h9001);
    step(SD, DE);
    flags = 3'b001;
    step(SE, BR);
    fetch(16'h9001);
    step(SD, DE);
    flags = 3'b000;
    step(SE, NO);
    // cond !Z with Z clear is taken; cond 101 never taken.
    fetch(16'h9002);
    step(SD, DE);
    step(SE, BR);
    fetch(16'h9005);
    step(SD, DE);
    flags = 3'b111;
    step(SE, NO);
    flags = 3'b000;

    // JUMP, then NOP with mem_ack noise outside MEM.
    fetch(16'h9800);
    step(SD, DE);
    step(SE, BR);
    fetch(16'hF000);
    mem_ack = 1'b1;
    step(SD, DE);
    step(SE, NO);
    mem_ack = 1'b0;
    step(SF, FE);

    // Illegal opcode 1_0100.
    fetch(16'hA000);
    step(SD, DE);
    step(SE, NO);
`ifdef CTRL_ILLEGAL_TRAP_EN
    step(SH, HLI);
    step(SH, HLI);
    do_reset();
`else
    step(SF, FE);
`endif

    // HALT holds through 20 cycles of instr_ack, then reset recovers.
    fetch(16'hF800);
    step(SD, DE);
    step(SE, NO);
    instr = 16'h0A53; instr_ack = 1'b1;
    for (int k = 0; k < 20; k++) step(SH, HL);
    check_now("halt_wait_expired", SH, HL);
    do_reset();
    instr_ack = 1'b0; instr = 16'h0000;
    step(SF, FE);

    // Reset during MEM: mem_req drops in the same cycle, later mem_ack ignored.
    fetch(16'h81A8);
    step(SD, DE);
    step(SE, NO);
    step(SM, ML);
    do_reset();
    mem_ack = 1'b1;
    step(SF, FE);
    step(SF, FE);
    mem_ack = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
